etg: RTL and testbench
======================

# etg

Enable tick generator: the upstream stage that drives the `en` input of the 4-bit up counter. It converts board buttons into counter control. It runs a programmable prescaler that emits single-cycle enable pulses, and supports run/pause toggling and single-step from raw push-buttons. It provides synchronization, debouncing and edge detection for both buttons.

## Interface
- `DIV`, default 50_000_000: base prescaler period in clock cycles (≥1).
- `DB_CYCLES`, default 1_000_000: cycles a synchronized button level must hold before it is accepted (≥1).
- `etg_clk`  in  1  system clock; all state updates on rising edge.
- `etg_rst`  in  1  reset, synchronous, active-high.
- `etg_run_btn`  in  1  raw asynchronous button; each press toggles run/pause.
- `etg_step_btn`  in  1  raw asynchronous button; each press while paused yields one tick.
- `etg_speed`  in  2  speed select; effective period `LIMIT = max(1, DIV >> etg_speed)`.
- `etg_en`  out  1  registered single-cycle enable pulse to the counter.
- `etg_running`  out  1  registered, 1 = RUNNING state.

## Operation
- Reset (`etg_rst`=1 at an edge) clears all of the following: synchronizer FFs, debounce counters, debounced levels, edge-detect registers, prescaler, state = PAUSED. `etg_en`=0 and `etg_running`=0. Reset wins over all other inputs.
- Synchronizer: 2-FF chain per button.
- Debounce: per button, a counter of consecutive cycles where the synchronized level ≠ the debounced level.
  - Any cycle where they match clears the counter.
  - On the DB_CYCLES-th consecutive mismatch, the debounced level flips and the counter clears.
  - Counter width: `$clog2(DB_CYCLES+1)`.
- Press: debounced level rises (0→1). Releases produce nothing.
- FSM, two states, PAUSED and RUNNING:
  - A run press toggles the state.
  - A step press in PAUSED sets `etg_en`=1 for the next cycle.
  - A step press in RUNNING is ignored.
  - A run press and a step press in the same cycle in PAUSED: run wins, step is dropped, no pulse.
- Prescaler: counter of width `$clog2(DIV)` (min 1).
  - In PAUSED it is held at 0.
  - In RUNNING it increments each cycle.
  - When `cnt >= LIMIT-1`: `etg_en`=1 next cycle and `cnt` ← 0. The `>=` covers a mid-count speed change to a shorter LIMIT.
  - With LIMIT=1, `etg_en` is high every cycle while RUNNING.
- State changes take effect on the following cycle. A terminal count in the same cycle as a pause press still emits its pulse. The prescaler is then cleared to 0 on entering PAUSED.
- Entering RUNNING starts the count from 0.
- `etg_en` is never high for two consecutive cycles, except when LIMIT=1.

## Timing
- Raw button first sampled high at edge k, held stable: the press takes effect at edge k+DB_CYCLES+2.
  - `etg_running` toggles at that edge, or
  - `etg_en` rises at that edge for a step press.
- Glitches shorter than DB_CYCLES synchronized cycles produce no press.
- Holding a button produces exactly one press. A further press requires release, which must also be debounced.
- RUNNING at a steady speed gives a pulse period of exactly LIMIT cycles. The first pulse comes LIMIT cycles after the edge where `etg_running` rose.
- `etg_speed` is sampled every cycle with no synchronization. It is intended to be quasi-static (switches).

## Test plan
Benches use DIV=8 and DB_CYCLES=4.
- Reset: assert `etg_rst` for 2 cycles with both buttons held high → `etg_en`=0 and `etg_running`=0 throughout and on the first edge after release. No press is seen until debounce completes after reset.
- Step: in PAUSED, raise step at edge k and hold for 10 cycles → `etg_en`=1 only during the cycle after edge k+6. The counter output advances by exactly 1. Release and press again → one more pulse.
- Run: press run → `etg_running`=1 at edge k+6. With speed=0, `etg_en` pulses every 8 cycles, first pulse 8 cycles later. With speed=2, period 2. With speed=3 (LIMIT=1), `etg_en` is high every cycle.
- Bounce: toggle run_btn with 1–3 cycle pulses for 30 cycles, then settle low → no state change and no `etg_en`.
- Simultaneous: in PAUSED, press run and step in the same cycle → RUNNING, no step pulse. In RUNNING, press step → ignored, period unchanged.
- Speed change mid-count: RUNNING with speed=0 and cnt=6; switch to speed=1 (LIMIT=4) → pulse on the next cycle, then every 4 cycles. A pause press coinciding with a terminal count → that pulse is still emitted, then no further pulses.

Source files
------------

// File: rtl/etg.sv
// Enable tick generator: debounced run/step buttons and a programmable prescaler
// producing single-cycle enable pulses for a downstream counter.
module etg #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       etg_clk,
  input  logic       etg_rst,
  input  logic       etg_run_btn,
  input  logic       etg_step_btn,
  input  logic [1:0] etg_speed,
  output logic       etg_en,
  output logic       etg_running
);

  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DbLast = DBW'(DB_CYCLES - 1);

  localparam logic [0:0] StPaused  = 1'b0;
  localparam logic [0:0] StRunning = 1'b1;

  // Bit 0 is the run button, bit 1 the step button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_q, db_d, db_prev_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];
  logic           run_press, step_press;

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           en_q, en_d;
  logic [31:0]    limit;
  logic           tc;

  assign btn_raw = {etg_step_btn, etg_run_btn};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign run_press  = db_q[0] & ~db_prev_q[0];
  assign step_press = db_q[1] & ~db_prev_q[1];

  always_comb begin
    limit = 32'(DIV) >> etg_speed;
    if (limit == 32'd0) limit = 32'd1;
  end

  // ">=" so a shortened LIMIT mid-count fires immediately instead of wrapping.
  assign tc = (32'(cnt_q) >= (limit - 32'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    en_d    = 1'b0;
    if (run_press) state_d = ~state_q;
    if (state_q == StRunning) begin
      if (tc) begin
        en_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (run_press) cnt_d = '0;
    end else begin
      en_d = step_press & ~run_press;
    end
  end

  always_ff @(posedge etg_clk) begin
    if (etg_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      state_q   <= StPaused;
      cnt_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
    end
  end

  assign etg_en      = en_q;
  assign etg_running = (state_q == StRunning);

endmodule

// File: tb/tb_etg.sv
// Scoreboard bench for etg: expected pulse/state-change edges are queued as stimulus is
// driven and matched against what the DUT shows after each rising edge.
module tb_etg;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_btn, step_btn;
  logic [1:0] speed;
  logic       en, running;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int exp_q[$];
  logic run_prev = 1'b0;

  etg #(.DIV(8), .DB_CYCLES(4)) dut (
    .etg_clk      (clk),
    .etg_rst      (rst),
    .etg_run_btn  (run_btn),
    .etg_step_btn (step_btn),
    .etg_speed    (speed),
    .etg_en       (en),
    .etg_running  (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, want, cyc);
    end
  endtask

  // Event code: edge*2 + kind, kind 0 = en pulse, 1 = running change.
  task automatic observe(input int kind);
    int code;
    code = cyc * 2 + kind;
    if (exp_q.size() == 0) check("unexpected_event", code, -1);
    else check(kind ? "running_edge" : "en_pulse", code, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (en === 1'b1) observe(0);
    if (running !== run_prev) observe(1);
    run_prev = running;
  end

  task automatic push_pulses(input int first, input int step, input int last);
    for (int c = first; c <= last; c += step) exp_q.push_back(c * 2);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; run_btn = 1'b1; step_btn = 1'b1; speed = 2'd0;
    // Reset with both buttons held high.
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check("rst_en", int'(en), 0);
      check("rst_running", int'(running), 0);
    end
    wait_until(2);
    rst = 1'b0;
    // Both presses land at edge 9 while paused: run wins, no step pulse.
    exp_q.push_back(9 * 2 + 1);
    push_pulses(17, 8, 49);
    @(negedge clk);
    check("post_rst_en", int'(en), 0);
    check("post_rst_running", int'(running), 0);

    wait_until(20); run_btn = 1'b0; step_btn = 1'b0;
    // Step press while running must not disturb the period.
    wait_until(30); step_btn = 1'b1;
    wait_until(40); step_btn = 1'b0;

    // After edge 55 the prescaler holds 6; LIMIT 4 fires at once, then every 4.
    wait_until(55); speed = 2'd1;
    push_pulses(56, 4, 64);
    wait_until(64); speed = 2'd2;
    push_pulses(66, 2, 80);
    wait_until(80); speed = 2'd3;
    push_pulses(81, 1, 90);
    wait_until(90); speed = 2'd0;
    push_pulses(98, 8, 114);

    // Pause press resolves at edge 114, the same edge as a terminal count.
    exp_q.push_back(114 * 2 + 1);
    wait_until(107); run_btn = 1'b1;
    wait_until(120); run_btn = 1'b0;

    // Bounce: short high glitches never survive debounce.
    wait_until(130);
    while (cyc < 160) begin
      run_btn = 1'b1;
      wait_until(cyc + int'($urandom_range(1, 3)));
      run_btn = 1'b0;
      wait_until(cyc + int'($urandom_range(1, 3)));
    end
    run_btn = 1'b0;

    // Two separate step presses while paused.
    wait_until(180); step_btn = 1'b1; exp_q.push_back(187 * 2);
    wait_until(190); step_btn = 1'b0;
    wait_until(200); step_btn = 1'b1; exp_q.push_back(207 * 2);
    wait_until(210); step_btn = 1'b0;

    wait_until(230);
    check("events_outstanding", exp_q.size(), 0);
    check("final_running", int'(running), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
